// File: rtl/polyshift_r_seq.sv
// Iterative right shifter (LOGIC/ARITH/carry/rotate), one bit position per clock, valid/ready on both sides.
// Optional feature: define POLYSHIFT_R_STICKY_EN to add sticky_o (OR of shifted-out bits except the last).
module polyshift_r_seq #(
    parameter  int WORD_WIDTH = 8,
    localparam int SIZE_W     = $clog2(WORD_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [WORD_WIDTH-1:0] d_i,
    input  logic [WORD_WIDTH-2:0] c_i,
    input  logic [SIZE_W-1:0]     shift_size_i,
    input  logic [1:0]            shift_type_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_WIDTH-1:0] d_o,
    output logic                  last_o
`ifdef POLYSHIFT_R_STICKY_EN
    ,
    output logic                  sticky_o
`endif
);

    typedef enum logic [1:0] {
        SH_LOGIC  = 2'd0,
        SH_ARITH  = 2'd1,
        SH_CARRY  = 2'd2,
        SH_ROTATE = 2'd3
    } shift_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] work_q;
    logic [WORD_WIDTH-2:0] carry_q;
    logic [SIZE_W-1:0]     cnt_q;
    shift_type_e           type_q;
    logic                  last_q;
    logic                  fill_bit;
    logic                  accept;

    assign accept = valid_i & ready_o;
    assign d_o    = work_q;
    assign last_o = last_q;

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_d = (shift_size_i == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == SIZE_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit entering at the MSB on each step; unknown encodings fall back to a logical shift.
    always_comb begin
        fill_bit = 1'b0;
        case (type_q)
            SH_ARITH:  fill_bit = work_q[WORD_WIDTH-1];
            SH_CARRY:  fill_bit = carry_q[0];
            SH_ROTATE: fill_bit = work_q[0];
            default:   fill_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            work_q  <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            type_q  <= SH_LOGIC;
            last_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                work_q  <= d_i;
                carry_q <= c_i;
                cnt_q   <= shift_size_i;
                type_q  <= shift_type_e'(shift_type_i);
                last_q  <= 1'b0;
            end
        end else if (state_q == BUSY) begin
            work_q  <= {fill_bit, work_q[WORD_WIDTH-1:1]};
            carry_q <= carry_q >> 1;
            cnt_q   <= cnt_q - SIZE_W'(1);
            last_q  <= work_q[0];
        end
    end

`ifdef POLYSHIFT_R_STICKY_EN
    logic sticky_q;
    assign sticky_o = sticky_q;

    // The previous last bit folds into sticky as soon as a newer bit replaces it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                sticky_q <= 1'b0;
            end
        end else if (state_q == BUSY) begin
            sticky_q <= sticky_q | last_q;
        end
    end
`endif

endmodule

// File: tb/tb_polyshift_r_seq.sv
// Self-checking bench for polyshift_r_seq: directed vectors plus a {hi,lo}>>size reference model.
module tb_polyshift_r_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] d_i = '0;
    logic [6:0] c_i = '0;
    logic [2:0] shift_size_i = '0;
    logic [1:0] shift_type_i = '0;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [7:0] d_o;
    logic       last_o;
`ifdef POLYSHIFT_R_STICKY_EN
    logic       sticky_o;
    logic       got_sticky;
`endif

    int tests = 0;
    int fails = 0;

    logic       exp_active = 1'b0;
    logic [7:0] exp_d = '0;
    logic       exp_last = 1'b0;
    logic       exp_sticky = 1'b0;

    polyshift_r_seq #(.WORD_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .d_i          (d_i),
        .c_i          (c_i),
        .shift_size_i (shift_size_i),
        .shift_type_i (shift_type_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .d_o          (d_o),
        .last_o       (last_o)
`ifdef POLYSHIFT_R_STICKY_EN
        ,
        .sticky_o     (sticky_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: place the fill word above the operand and shift the pair right in one go.
    function automatic logic [15:0] wide_of(input logic [1:0] t, input logic [7:0] d, input logic [6:0] c);
        case (t)
            2'd1:    return {{8{d[7]}}, d};
            2'd2:    return {1'b0, c, d};
            2'd3:    return {d, d};
            default: return {8'h00, d};
        endcase
    endfunction

    function automatic logic [7:0] model_d(input logic [1:0] t, input logic [7:0] d, input logic [6:0] c, input int sz);
        logic [15:0] w;
        w = wide_of(t, d, c) >> sz;
        return w[7:0];
    endfunction

    function automatic logic model_last(input logic [7:0] d, input int sz);
        return (sz == 0) ? 1'b0 : d[sz-1];
    endfunction

    function automatic logic model_sticky(input logic [7:0] d, input int sz);
        logic [7:0] mask;
        if (sz < 2) return 1'b0;
        mask = 8'((16'h1 << (sz - 1)) - 16'h1);
        return |(d & mask);
    endfunction

    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (!exp_active) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                check("d_o", 32'(d_o), 32'(exp_d));
                check("last_o", 32'(last_o), 32'(exp_last));
`ifdef POLYSHIFT_R_STICKY_EN
                check("sticky_o", 32'(sticky_o), 32'(exp_sticky));
`endif
            end
        end
    end

    task automatic run_req(input logic [1:0] t, input logic [7:0] d, input logic [6:0] c, input int sz,
                           input int hold, output logic [7:0] got_d, output logic got_last);
        int n;
        n = 0;
        while (!ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(ready_o), 32'd1);
        valid_i      = 1'b1;
        d_i          = d;
        c_i          = c;
        shift_size_i = 3'(sz);
        shift_type_i = t;
        exp_d        = model_d(t, d, c, sz);
        exp_last     = model_last(d, sz);
        exp_sticky   = model_sticky(d, sz);
        exp_active   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i      = 1'b0;
        d_i          = 8'($urandom);
        c_i          = 7'($urandom);
        shift_size_i = 3'($urandom);
        shift_type_i = 2'($urandom);
        n = 1;
        while (!valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(sz + 1));
        got_d    = d_o;
        got_last = last_o;
`ifdef POLYSHIFT_R_STICKY_EN
        got_sticky = sticky_o;
`endif
        for (int i = 0; i < hold; i++) begin
            valid_i = 1'b1;
            d_i     = 8'($urandom);
            @(negedge clk);
            check("bp_valid_o", 32'(valid_o), 32'd1);
            check("bp_ready_o", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("ready_after_handshake", 32'(ready_o), 32'd1);
        check("valid_after_handshake", 32'(valid_o), 32'd0);
        exp_active = 1'b0;
    endtask

    initial begin
        logic [7:0] gd;
        logic       gl;

        repeat (2) @(negedge clk);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_d_o", 32'(d_o), 32'd0);
        check("rst_last_o", 32'(last_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Pin the model itself with hand-computed values.
        check("model_logic", 32'(model_d(2'd0, 8'hB6, 7'h00, 3)), 32'h16);
        check("model_carry", 32'(model_d(2'd2, 8'h0F, 7'h53, 4)), 32'h30);
        check("model_rotate", 32'(model_d(2'd3, 8'h0F, 7'h00, 4)), 32'hF0);

        // Reset in the middle of a long operation.
        valid_i      = 1'b1;
        d_i          = 8'hFF;
        shift_size_i = 3'd7;
        shift_type_i = 2'd0;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_valid_o", 32'(valid_o), 32'd0);
        check("abort_ready_o", 32'(ready_o), 32'd1);
        check("abort_d_o", 32'(d_o), 32'd0);
        check("abort_last_o", 32'(last_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_req(2'd0, 8'b1011_0110, 7'h00, 3, 0, gd, gl);
        check("logic_d", 32'(gd), 32'h16);
        check("logic_last", 32'(gl), 32'd1);

        run_req(2'd1, 8'b1000_0001, 7'h00, 7, 0, gd, gl);
        check("arith7_d", 32'(gd), 32'hFF);
        check("arith7_last", 32'(gl), 32'd0);

        run_req(2'd1, 8'b1000_0001, 7'h00, 0, 0, gd, gl);
        check("arith0_d", 32'(gd), 32'h81);
        check("arith0_last", 32'(gl), 32'd0);

        run_req(2'd2, 8'h0F, 7'b101_0011, 4, 0, gd, gl);
        check("carry_d", 32'(gd), 32'h30);
        check("carry_last", 32'(gl), 32'd1);

        run_req(2'd3, 8'h0F, 7'h00, 4, 0, gd, gl);
        check("rotate_d", 32'(gd), 32'hF0);

        run_req(2'd1, 8'hC3, 7'h2A, 2, 5, gd, gl);
        check("bp_d", 32'(gd), 32'hF0);
        check("bp_last", 32'(gl), 32'd1);

        for (int t = 0; t < 4; t++) begin
            for (int sz = 0; sz < 8; sz++) begin
                run_req(2'(t), 8'($urandom), 7'($urandom), sz, sz % 2, gd, gl);
            end
        end

`ifdef POLYSHIFT_R_STICKY_EN
        run_req(2'd0, 8'b0000_0101, 7'h00, 3, 0, gd, gl);
        check("sticky_last", 32'(gl), 32'd1);
        check("sticky_val", 32'(got_sticky), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
